// File: rtl/fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// fifo_sync_flags
//
// Single-clock synchronous FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, one-cycle overflow/underflow error pulses and a
// selectable read mode: registered read (FWFT=0) or first-word-fall-through
// (FWFT=1).
//
// Parameters:
//   width     data word width in bits
//   Depth     number of entries (power of two, >= 4)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//   FWFT      0 = data_out registered on an accepted read,
//             1 = data_out shows the head word whenever not empty
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   wr_en         write request, accepted when not full
//   data_in       write data
//   rd_en         read request, accepted when not empty
//   data_out      read data
//   full          count == Depth
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..Depth
//   overflow      high for the cycle after a rejected write
//   underflow     high for the cycle after a rejected read
// -----------------------------------------------------------------------------
module fifo_sync_flags #(
   parameter int unsigned width    = 32,
   parameter int unsigned Depth    = 128,
   parameter int unsigned AF_LEVEL = Depth - 4,
   parameter int unsigned AE_LEVEL = 4,
   parameter bit          FWFT     = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [width-1:0]       data_in,
   input  logic                   rd_en,
   output logic [width-1:0]       data_out,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(Depth):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [CntW-1:0] CntFull = CntW'(Depth);
   localparam logic [CntW-1:0] AfLevel = CntW'(AF_LEVEL);
   localparam logic [CntW-1:0] AeLevel = CntW'(AE_LEVEL);

   // Storage and state
   logic [width-1:0] mem_q [Depth];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             wr_acc;
   logic             rd_acc;

   // Flags are decoded from the registered count only, so they describe the
   // state left by the previous edge and never depend on this cycle's requests.
   always_comb begin
      full         = (count_q == CntFull);
      empty        = (count_q == '0);
      almost_full  = (count_q >= AfLevel);
      almost_empty = (count_q <= AeLevel);
   end

   // Acceptance and next state. A write while full is refused even if a read
   // is accepted in the same cycle, and vice versa for a read while empty.
   always_comb begin
      wr_acc      = wr_en & ~full;
      rd_acc      = rd_en & ~empty;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      overflow_d  = wr_en & full;
      underflow_d = rd_en & empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Memory is deliberately not reset; a write presented during reset is
   // dropped so it cannot disturb contents behind the cleared pointers.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Read data path
   if (FWFT) begin : g_fwft
      // Head word is exposed directly; rd_en only acknowledges and pops it.
      assign data_out = mem_q[rd_ptr_q];
   end else begin : g_std
      logic [width-1:0] dout_q, dout_d;

      always_comb begin
         dout_d = dout_q;
         if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign data_out = dout_q;
   end

endmodule
